// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: opcodes, FSM encoding and default width.
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // SRL by zero takes the single-cycle path; only non-zero amounts iterate.
  function automatic logic srl_iterates(input logic [2:0] op, input logic [4:0] amt);
    return (op == OP_SRL) && (amt != 5'd0);
  endfunction

endpackage

// File: rtl/alu_logic_unit.sv
// Combinational bitwise/arithmetic unit for every opcode except SRL.
module alu_logic_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             overflow_o
);

  logic             is_add_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   sum_s;
  logic             lt_s;

  // One adder serves ADD and SUB; SUB is a + ~b + 1.
  always_comb begin
    is_add_s = (op_i == OP_ADD);
    b_eff_s  = is_add_s ? b_i : ~b_i;
    sum_s    = {1'b0, a_i} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, ~is_add_s};
    lt_s     = ($signed(a_i) < $signed(b_i));
  end

  always_comb begin
    result_o   = {WIDTH{1'b0}};
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    case (op_i)
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_NOR: result_o = ~(a_i | b_i);
      OP_ADD, OP_SUB: begin
        result_o   = sum_s[WIDTH-1:0];
        carry_o    = sum_s[WIDTH];
        overflow_o = (a_i[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SLT: result_o = {{(WIDTH-1){1'b0}}, lt_s};
      default: result_o = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: valid/ready in, held result plus flags out,
// with an iterative one-bit-per-cycle logical right shifter.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d, in_ready_q, in_ready_d;
  logic             accept_s;
  logic [WIDTH-1:0] shifted_s, lu_result_s;
  logic             lu_carry_s, lu_ovf_s;

  assign accept_s  = (state_q == ST_IDLE) && in_ready_q && in_valid;
  assign shifted_s = {1'b0, a_q[WIDTH-1:1]};

  alu_logic_unit #(.WIDTH(WIDTH)) u_logic (
    .op_i       (op_q),
    .a_i        (a_q),
    .b_i        (b_q),
    .result_o   (lu_result_s),
    .carry_o    (lu_carry_s),
    .overflow_o (lu_ovf_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = srl_iterates(alu_op, b[4:0]) ? ST_SHIFT : ST_EXEC;
        else          state_d = ST_IDLE;
      end
      ST_EXEC:  state_d = ST_HOLD;
      ST_SHIFT: begin
        if (cnt_q == 5'd1) state_d = ST_HOLD;
        else               state_d = ST_SHIFT;
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
        else           state_d = ST_HOLD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // a_q doubles as the shift working register once an SRL is in flight.
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          op_d  = alu_op;
          a_d   = a;
          b_d   = b;
          cnt_d = b[4:0];
        end else begin
          op_d = op_q;
        end
      end
      ST_EXEC: begin
        if (op_q == OP_SRL) begin
          result_d = a_q;
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
        end else begin
          result_d = lu_result_s;
          carry_d  = lu_carry_s;
          ovf_d    = lu_ovf_s;
        end
        zero_d = (result_d == {WIDTH{1'b0}});
      end
      ST_SHIFT: begin
        a_d   = shifted_s;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          result_d = shifted_s;
          zero_d   = (shifted_s == {WIDTH{1'b0}});
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
        end else begin
          result_d = result_q;
        end
      end
      ST_HOLD: result_d = result_q;
      default: result_d = result_q;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= OP_AND;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      cnt_q       <= 5'd0;
      result_q    <= {WIDTH{1'b0}};
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;

endmodule
